// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the 1-1-0-1-1 serial pattern detector.
//   state_t          - FSM state enum (S0..S4), STATE_W bits wide
//   PATTERN          - target bit pattern, MSB is the first bit received
//   OVERLAP_RESTART  - state re-entered after a hit when overlap is enabled
package seq_det_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,   // idle
        S1 = 3'd1,   // seen "1"
        S2 = 3'd2,   // seen "11"
        S3 = 3'd3,   // seen "110"
        S4 = 3'd4    // seen "1101"
    } state_t;

    localparam logic [4:0] PATTERN = 5'b11011;

    // The trailing "11" of a hit is also the leading "11" of the next one.
    localparam state_t OVERLAP_RESTART = S2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: generic saturating up-counter.
//   clk - rising-edge clock
//   rst - asynchronous active-low reset (clears cnt)
//   inc - increment request, sampled on the rising edge
//   cnt - W-bit count, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_11011_mealy.sv
// seq_11011_mealy: Mealy detector for the serial pattern 1-1-0-1-1.
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset
//   x       - serial data bit, sampled on the rising edge
//   y       - detection pulse, high while the final '1' is on x
//   det_cnt - saturating count of detections since reset
// Parameters: OVERLAP (1 = restart from "11" after a hit, 0 = restart idle),
//             CNT_W (det_cnt width).
// Build option: SEQ_11011_REG_OUT_EN registers y (one cycle later,
// glitch-free); det_cnt timing is unaffected.
module seq_11011_mealy
    import seq_det_pkg::*;
#(
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] det_cnt
);

    localparam state_t RESTART = OVERLAP ? OVERLAP_RESTART : S0;

    state_t state, state_nxt;
    logic   det;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state advances when x matches the next pattern bit. In S2 a
    // further '1' keeps "11" as the longest matched prefix, so stay put.
    always_comb begin
        state_nxt = S0;
        det       = 1'b0;
        case (state)
            S0: state_nxt = (x == PATTERN[4]) ? S1 : S0;
            S1: state_nxt = (x == PATTERN[3]) ? S2 : S0;
            S2: state_nxt = (x == PATTERN[2]) ? S3 : S2;
            S3: state_nxt = (x == PATTERN[1]) ? S4 : S0;
            S4: begin
                if (x == PATTERN[0]) begin
                    det       = 1'b1;
                    state_nxt = RESTART;
                end else begin
                    state_nxt = S0;
                end
            end
            default: state_nxt = S0;
        endcase
    end

`ifdef SEQ_11011_REG_OUT_EN
    logic y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= det;
        end
    end

    assign y = y_q;
`else
    assign y = det;
`endif

    sat_counter #(
        .W(CNT_W)
    ) u_det_cnt (
        .clk(clk),
        .rst(rst),
        .inc(det),
        .cnt(det_cnt)
    );

endmodule

// File: tb/tb_seq_11011_mealy.sv
// tb_seq_11011_mealy: self-checking bench for seq_11011_mealy.
// Three instances share one stimulus stream: default (OVERLAP=1, CNT_W=8),
// non-overlapping (OVERLAP=0), and a 2-bit counter (CNT_W=2).
// Honours SEQ_11011_REG_OUT_EN: expected y then lags the detect by a cycle.
module tb_seq_11011_mealy;

`ifdef SEQ_11011_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic       y0, y1, y2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    always #5 clk = ~clk;

    seq_11011_mealy dut_ovl (
        .clk(clk), .rst(rst), .x(x), .y(y0), .det_cnt(c0)
    );

    seq_11011_mealy #(.OVERLAP(1'b0)) dut_novl (
        .clk(clk), .rst(rst), .x(x), .y(y1), .det_cnt(c1)
    );

    seq_11011_mealy #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .x(x), .y(y2), .det_cnt(c2)
    );

    logic        ya[3];
    int unsigned ca[3];
    always_comb begin
        ya[0] = y0; ya[1] = y1; ya[2] = y2;
        ca[0] = 32'(c0); ca[1] = 32'(c1); ca[2] = 32'(c2);
    end

    // Reference model: a bit history per instance; a hit is "the last five
    // bits received since the last reset (or, without overlap, since the
    // last hit) spell 11011".
    bit          ovl[3]  = '{1'b1, 1'b0, 1'b1};
    int unsigned cmax[3] = '{255, 255, 3};
    logic [4:0]  hist[3];
    int unsigned hlen[3];
    int unsigned mcnt[3];
    logic        prev_hit[3];

    int passed = 0;
    int total  = 0;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0; hlen[i] = 0; mcnt[i] = 0; prev_hit[i] = 1'b0;
        end
    endtask

    task automatic step(input logic b);
        logic hit[3];
        logic exp_y;
        @(negedge clk);
        x = b;
        #1;
        for (int i = 0; i < 3; i++) begin
            hist[i] = {hist[i][3:0], b};
            if (hlen[i] < 100) hlen[i]++;
            hit[i] = (hlen[i] >= 5) && (hist[i] == 5'b11011);
            exp_y  = REG ? prev_hit[i] : hit[i];
            total++;
            if (ya[i] !== exp_y)
                $display("FAIL y[%0d] t=%0t got=%b exp=%b", i, $time, ya[i], exp_y);
            else
                passed++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (hit[i]) begin
                if (mcnt[i] < cmax[i]) mcnt[i]++;
                if (!ovl[i]) hlen[i] = 0;
            end
            prev_hit[i] = hit[i];
            total++;
            if (ca[i] !== mcnt[i])
                $display("FAIL det_cnt[%0d] t=%0t got=%0d exp=%0d", i, $time, ca[i], mcnt[i]);
            else
                passed++;
        end
    endtask

    // Bits are presented MSB first, starting at bit n-1.
    task automatic feed(input logic [63:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(bits[k]);
    endtask

    // Hold reset for n cycles with random x; outputs must stay cleared.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            x = 1'($urandom);
            #1;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ya[i] !== 1'b0 || ca[i] !== 0)
                    $display("FAIL reset[%0d] t=%0t got y=%b cnt=%0d exp y=0 cnt=0",
                             i, $time, ya[i], ca[i]);
                else
                    passed++;
            end
            @(negedge clk);
        end
        model_clear();
        rst = 1'b1;
    endtask

    task automatic check_cnt(input string name, input int unsigned got,
                             input int unsigned exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        do_reset(6);
        feed(64'b00000, 5);
    endtask

    task automatic test_single_hit();
        do_reset(1);
        feed(64'b11011, 5);
        total++;
        if (c0 !== 8'd1 || c1 !== 8'd1 || c2 !== 2'd1)
            $display("FAIL single_hit got=%0d/%0d/%0d exp=1/1/1", c0, c1, c2);
        else
            passed++;
    endtask

    task automatic test_overlap();
        do_reset(1);
        feed(64'b11011011011, 11);
        check_cnt("overlap_cnt", 32'(c0), 3);
        check_cnt("nonoverlap_cnt", 32'(c1), 2);
    endtask

    task automatic test_near_miss();
        do_reset(1);
        feed(64'b11010110011101, 14);
        check_cnt("near_miss_before", 32'(c0), 0);
        step(1'b1);
        check_cnt("near_miss_tail", 32'(c0), 1);
        check_cnt("near_miss_tail_novl", 32'(c1), 1);
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        feed(64'b1101, 4);
        do_reset(1);
        step(1'b1);
        check_cnt("reset_mid_discard", 32'(c0), 0);
        feed(64'b11011, 5);
        check_cnt("reset_mid_rehit", 32'(c0), 1);
    endtask

    task automatic test_saturation();
        int unsigned exp_sat[5] = '{1, 2, 3, 3, 3};
        do_reset(1);
        feed(64'b11011, 5);
        check_cnt("sat_hit1", 32'(c2), exp_sat[0]);
        for (int k = 1; k < 5; k++) begin
            feed(64'b011, 3);
            check_cnt($sformatf("sat_hit%0d", k + 1), 32'(c2), exp_sat[k]);
        end
        check_cnt("sat_wide_cnt", 32'(c0), 5);
    endtask

    task automatic test_random();
        do_reset(1);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            step($urandom_range(0, 9) < 6);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_hit();
        test_overlap();
        test_near_miss();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_11011_mealy.md
Name: seq_11011_mealy

Overview:
Mealy-type serial pattern detector for the bit sequence 1-1-0-1-1 on a 1-bit input stream sampled once per clock. Output y pulses combinationally in the cycle the final '1' of the pattern is present on x. Overlapping detection is supported. A saturating detection counter is provided for status and debug. The block sits on a serial bit stream alongside other small control FSMs.

Parameters:
OVERLAP, 1, 1 = overlapping detection (restart from the "11" state after a hit); 0 = non-overlapping (restart from idle).
CNT_W, 8, width of the det_cnt detection counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (asserted at 0).
x  input  1  serial data bit, synchronous to clk, sampled on the rising edge.
y  output  1  detection pulse; Mealy output (combinational from state and x).
det_cnt  output  CNT_W  number of detections since reset; saturating.

Behaviour:
- State encoding lives in the package:
  - S0: idle.
  - S1: seen "1".
  - S2: seen "11".
  - S3: seen "110".
  - S4: seen "1101".
- State register updates on the rising edge of clk; rst=0 forces S0 immediately (asynchronous).
- Transitions are listed as x=0 / x=1:
  - S0: S0 / S1.
  - S1: S0 / S2.
  - S2: S3 / S2.
  - S3: S0 / S4.
  - S4: S0 / (S2 if OVERLAP=1, else S0).
- Output y = 1 only when state==S4 and x==1; otherwise y = 0.
  - Zero latency: y rises in the same cycle as the final bit.
  - y is valid until the next rising edge.
- While rst=0: state is S0, so y=0; det_cnt=0.
- det_cnt: increments by 1 on each rising edge where y==1.
  - Holds at all-ones and does not wrap.
  - Reset value is 0.
- Reset asserted mid-pattern discards partial progress. After release, the pattern must be presented in full again.
- Runs of consecutive 1s keep the FSM in S2; "111011" yields exactly one detection, on the last bit.
- Unreachable state codes return to S0 on the next clock edge with y=0.

Optional Feature:
- Macro: SEQ_11011_REG_OUT_EN.
- When defined:
  - y is driven from a flop loaded with the Mealy detect term. It pulses exactly one cycle later than in the base design, is glitch-free, and resets to 0.
  - det_cnt still counts the combinational detect term, so counter timing is unchanged.
- When undefined: y is purely combinational, as described under Behaviour.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum type (S0..S4) and its 3-bit width;
  - the target pattern constant 5'b11011;
  - the restart-state constant used for overlap.
- One natural sub-module, sat_counter: a generic CNT_W-bit saturating incrementer with async active-low reset. It is instantiated for det_cnt.
- The FSM stays in seq_11011_mealy.

Test Plan:
1. Reset:
   - Hold rst=0 with x toggling → y=0, det_cnt=0 throughout.
   - Release rst (set to 1), then feed x=0 for 5 cycles → y stays 0.
2. Single hit:
   - After reset, feed x=1,1,0,1,1 → y=1 exactly during the 5th bit cycle; det_cnt becomes 1 after that clock edge.
3. Overlap with OVERLAP=1:
   - Feed 1,1,0,1,1,0,1,1,0,1,1 → y=1 at bits 5, 8 and 11; det_cnt=3.
   - Repeat with OVERLAP=0 → y=1 at bits 5 and 11 only; det_cnt=2.
4. Near misses:
   - Feed 1,1,0,1,0,1,1,0,0,1,1,1,0,1,1 → the only hit is at bit 15 (the "111011" tail); y=0 elsewhere.
5. Reset mid-pattern:
   - Feed 1,1,0,1, assert rst=0 for one cycle, then feed 1 → no detection.
   - Then feed 1,1,0,1,1 → hit on the last bit.
6. Saturation with CNT_W=2:
   - Trigger 5 overlapping hits → det_cnt reads 1, 2, 3, 3, 3.
   - Also build with SEQ_11011_REG_OUT_EN and check y lags the base-design y by exactly one cycle.
